// File: rtl/ft245_pkg.sv
// Shared types and timing defaults for the FT245 bus sequencer.
package ft245_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RECOVER
    } state_t;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    localparam int DEF_RD_LOW_CYC   = 6;
    localparam int DEF_WR_SETUP_CYC = 2;
    localparam int DEF_WR_HIGH_CYC  = 6;
    localparam int DEF_WR_HOLD_CYC  = 2;
    localparam int DEF_RECOV_CYC    = 4;

    // The counter counts down to zero, so a phase of N cycles loads N-1.
    function automatic logic [3:0] cnt_load(input int cyc);
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/ft_sync2.sv
// Two-flop synchronizer with asynchronous reset to a chosen value.
module ft_sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ft245_bus_ctrl.sv
// FT245 async FIFO bus sequencer: round-robin shares the half-duplex bus
// between an RX byte stream and a TX byte stream with programmable strobes.
module ft245_bus_ctrl
    import ft245_pkg::*;
#(
    parameter int RD_LOW_CYC   = DEF_RD_LOW_CYC,
    parameter int WR_SETUP_CYC = DEF_WR_SETUP_CYC,
    parameter int WR_HIGH_CYC  = DEF_WR_HIGH_CYC,
    parameter int WR_HOLD_CYC  = DEF_WR_HOLD_CYC,
    parameter int RECOV_CYC    = DEF_RECOV_CYC
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic       ft_rxf_n,
    input  logic       ft_txe_n,
    input  logic       ft_pwr_n,
    input  logic [7:0] ft_data_in,
    output logic [7:0] ft_data_out,
    output logic [7:0] ft_data_oe,
    output logic       ft_rd_n,
    output logic       ft_wr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       link_up,
    output logic       busy
);

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       tx_full;
    logic [7:0] tx_buf;
    logic       rxf_s, txe_s, pwr_s;
    logic       rd_req, wr_req, cnt_done;

    ft_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_rxf (.clk(clk100), .rst(rst), .d(ft_rxf_n), .q(rxf_s));
    ft_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_txe (.clk(clk100), .rst(rst), .d(ft_txe_n), .q(txe_s));
    ft_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_pwr (.clk(clk100), .rst(rst), .d(ft_pwr_n), .q(pwr_s));

    assign link_up  = ~pwr_s;
    assign busy     = (state != IDLE);
    assign tx_ready = ~tx_full;
    assign cnt_done = (cnt == 4'd0);

    // A pending rx byte blocks further reads, so the consumer can never be overrun.
    assign rd_req = ~rxf_s & ~rx_valid & link_up;
    assign wr_req = ~txe_s & tx_full & link_up;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_grant  <= GRANT_WR;
            tx_full     <= 1'b0;
            tx_buf      <= 8'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            ft_rd_n     <= 1'b1;
            ft_wr       <= 1'b0;
            ft_data_oe  <= 8'h00;
            ft_data_out <= 8'h00;
        end else begin
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (tx_valid && tx_ready) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            // Pin outputs are set on the edge that enters each phase.
            case (state)
                IDLE: begin
                    if (rd_req && (!wr_req || last_grant == GRANT_WR)) begin
                        state      <= RD_LOW;
                        cnt        <= cnt_load(RD_LOW_CYC);
                        last_grant <= GRANT_RD;
                        ft_rd_n    <= 1'b0;
                    end else if (wr_req) begin
                        state       <= WR_SETUP;
                        cnt         <= cnt_load(WR_SETUP_CYC);
                        last_grant  <= GRANT_WR;
                        ft_data_out <= tx_buf;
                        ft_data_oe  <= 8'hFF;
                    end
                end
                RD_LOW: begin
                    if (cnt_done) begin
                        rx_data  <= ft_data_in;
                        rx_valid <= 1'b1;
                        ft_rd_n  <= 1'b1;
                        state    <= RECOVER;
                        cnt      <= cnt_load(RECOV_CYC);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_SETUP: begin
                    if (cnt_done) begin
                        ft_wr <= 1'b1;
                        state <= WR_PULSE;
                        cnt   <= cnt_load(WR_HIGH_CYC);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_PULSE: begin
                    if (cnt_done) begin
                        ft_wr <= 1'b0;
                        state <= WR_HOLD;
                        cnt   <= cnt_load(WR_HOLD_CYC);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    if (cnt_done) begin
                        ft_data_oe <= 8'h00;
                        tx_full    <= 1'b0;
                        state      <= RECOVER;
                        cnt        <= cnt_load(RECOV_CYC);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    if (cnt_done)
                        state <= IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_bus_ctrl.sv
// Directed bench for ft245_bus_ctrl with a simple FT245 FIFO model.
module tb_ft245_bus_ctrl;

    localparam logic [7:0] G_R = 8'h52;
    localparam logic [7:0] G_W = 8'h57;

    logic       clk100 = 1'b0;
    logic       rst;
    logic       ft_rxf_n, ft_txe_n, ft_pwr_n;
    logic [7:0] ft_data_in, ft_data_out, ft_data_oe;
    logic       ft_rd_n, ft_wr;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       link_up, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fifo_mem [16];
    int rd_done = 0;
    int rd_lo = 0, wr_hi = 0, rxv_hi = 0;
    int rd_lens[$], wr_lens[$];
    logic [7:0] wr_bytes[$], rx_got[$], grants[$];

    always #5 clk100 = ~clk100;

    assign ft_data_in = fifo_mem[rd_done[3:0]];

    ft245_bus_ctrl dut (
        .clk100(clk100), .rst(rst),
        .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .ft_pwr_n(ft_pwr_n),
        .ft_data_in(ft_data_in), .ft_data_out(ft_data_out), .ft_data_oe(ft_data_oe),
        .ft_rd_n(ft_rd_n), .ft_wr(ft_wr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .link_up(link_up), .busy(busy)
    );

    // Bus monitor: strobe lengths, grant order, bytes written/consumed.
    always @(negedge clk100) begin
        if (!ft_rd_n) begin
            if (rd_lo == 0) grants.push_back(G_R);
            rd_lo++;
        end else if (rd_lo != 0) begin
            rd_lens.push_back(rd_lo);
            rd_lo = 0;
            rd_done++;
        end
        if (ft_wr) begin
            if (wr_hi == 0) grants.push_back(G_W);
            wr_hi++;
        end else if (wr_hi != 0) begin
            wr_lens.push_back(wr_hi);
            wr_bytes.push_back(ft_data_out);
            wr_hi = 0;
        end
        if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk100); #1; end
    endtask

    // which: 0 rd_n==val, 1 rd_done>=val, 2 rx_valid==val, 3 ft_wr==val, 4 busy==val
    task automatic wait_for(input int which, input int val, input int bound, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick(1);
            case (which)
                0: ok = (int'(ft_rd_n) == val);
                1: ok = (rd_done >= val);
                2: ok = (int'(rx_valid) == val);
                3: ok = (int'(ft_wr) == val);
                default: ok = (int'(busy) == val);
            endcase
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        int base_g, base_w, base_r;
        logic hs;

        rst = 1'b1; ft_rxf_n = 1'b1; ft_txe_n = 1'b1; ft_pwr_n = 1'b0;
        rx_ready = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;
        fifo_mem[0] = 8'hA5;
        fifo_mem[1] = 8'h01; fifo_mem[2] = 8'h02; fifo_mem[3] = 8'h03; fifo_mem[4] = 8'h04;
        fifo_mem[5] = 8'h5A; fifo_mem[6] = 8'h6B;
        fifo_mem[7] = 8'hEE; fifo_mem[8] = 8'hC3;

        // Reset values
        tick(3);
        chk("rst_rd_n", ft_rd_n, 1);
        chk("rst_wr", ft_wr, 0);
        chk("rst_oe", ft_data_oe, 8'h00);
        chk("rst_dout", ft_data_out, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_link_up", link_up, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        tick(4);
        chk("link_up_after_sync", link_up, 1);

        // Single read: RD# falls on the third edge after RXF# goes low
        ft_rxf_n = 1'b0;
        tick(1); chk("rd_lat1", ft_rd_n, 1);
        tick(1); chk("rd_lat2", ft_rd_n, 1);
        tick(1); chk("rd_lat3", ft_rd_n, 0);
        ft_rxf_n = 1'b1;
        for (int k = 4; k <= 8; k++) begin
            tick(1); chk("rd_low_hold", ft_rd_n, 0);
        end
        tick(1);
        chk("rd_end_rd_n", ft_rd_n, 1);
        chk("rd_rx_valid", rx_valid, 1);
        chk("rd_rx_data", rx_data, 8'hA5);
        tick(1); chk("rd_rx_pulse", rx_valid, 0);
        tick(2); chk("rd_recover_busy", busy, 1);
        tick(1); chk("rd_idle", busy, 0);
        chk("rd_len", rd_lens[$], 6);

        // Single write: handshake in cycle N, checked for N+1..N+14
        ft_txe_n = 1'b0;
        tick(3);
        tx_data = 8'h3C; tx_valid = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            tx_valid = 1'b0;
            chk("wr_strobe", ft_wr, (k >= 4 && k <= 9) ? 1 : 0);
            chk("wr_oe", ft_data_oe, (k >= 2 && k <= 11) ? 8'hFF : 8'h00);
            chk("wr_tx_ready", tx_ready, (k >= 12) ? 1 : 0);
            if (k >= 2 && k <= 11) chk("wr_data", ft_data_out, 8'h3C);
            chk("wr_rd_n_idle", ft_rd_n, 1);
        end
        ft_txe_n = 1'b1;
        tick(4);

        // Contention: both sides pending, read wins first (last grant was write)
        base_g = grants.size(); base_w = wr_bytes.size(); base_r = rx_got.size();
        tx_data = 8'h01; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("cont_preload", tx_ready, 0);
        tick(3);
        ft_rxf_n = 1'b0; ft_txe_n = 1'b0;
        fork
            begin
                for (int b = 2; b <= 4; b++) begin
                    tx_data = 8'(b); tx_valid = 1'b1;
                    hs = 1'b0;
                    for (int i = 0; i < 200 && !hs; i++) begin
                        hs = tx_ready;
                        tick(1);
                    end
                    chk("cont_tx_accept", hs, 1);
                end
                tx_valid = 1'b0;
            end
            begin
                wait_for(1, 5, 400, "cont_reads_done");
                ft_rxf_n = 1'b1;
            end
        join
        for (int i = 0; i < 400 && wr_bytes.size() < base_w + 4; i++) tick(1);
        tick(10);
        ft_txe_n = 1'b1;
        for (int i = 0; i < 8; i++)
            chk("cont_grant", grants[base_g + i], (i % 2 == 0) ? G_R : G_W);
        chk("cont_grant_count", grants.size(), base_g + 8);
        for (int i = 0; i < 4; i++) begin
            chk("cont_rx_byte", rx_got[base_r + i], i + 1);
            chk("cont_wr_byte", wr_bytes[base_w + i], i + 1);
        end

        // Backpressure: second read waits for rx_ready
        rx_ready = 1'b0; ft_rxf_n = 1'b0;
        wait_for(2, 1, 50, "bp_first_valid");
        chk("bp_first_data", rx_data, 8'h5A);
        tick(20);
        chk("bp_no_second_rd", rd_done, 6);
        chk("bp_rd_n_idle", ft_rd_n, 1);
        chk("bp_valid_held", rx_valid, 1);
        chk("bp_data_held", rx_data, 8'h5A);
        rx_ready = 1'b1;
        wait_for(1, 7, 50, "bp_second_rd");
        ft_rxf_n = 1'b1;
        tick(12);
        chk("bp_got_first", rx_got[$-1], 8'h5A);
        chk("bp_got_second", rx_got[$], 8'h6B);

        // Link down: nothing starts; raising PWR# mid-pulse lets the write finish
        ft_pwr_n = 1'b1;
        tick(5);
        chk("ld_link_up", link_up, 0);
        base_g = grants.size();
        ft_rxf_n = 1'b0; ft_txe_n = 1'b0;
        tx_data = 8'h77; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("ld_tx_accepted", tx_ready, 0);
        tick(20);
        chk("ld_no_grants", grants.size(), base_g);
        chk("ld_busy", busy, 0);
        chk("ld_rd_n", ft_rd_n, 1);
        ft_rxf_n = 1'b1;
        tick(3);
        ft_pwr_n = 1'b0;
        wait_for(3, 1, 30, "ld_wr_start");
        ft_pwr_n = 1'b1;
        wait_for(4, 0, 40, "ld_wr_finish");
        tick(1);
        chk("ld_wr_byte", wr_bytes[$], 8'h77);
        chk("ld_wr_len", wr_lens[$], 6);
        chk("ld_tx_ready", tx_ready, 1);
        chk("ld_one_grant", grants.size(), base_g + 1);
        tick(10);
        chk("ld_still_idle", grants.size(), base_g + 1);
        chk("ld_link_down", link_up, 0);
        ft_txe_n = 1'b1;

        // Reset in the middle of RD_LOW
        ft_pwr_n = 1'b0;
        tick(4);
        ft_rxf_n = 1'b0;
        wait_for(0, 0, 20, "rst_rd_start");
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rd_n", ft_rd_n, 1);
        chk("mid_rst_oe", ft_data_oe, 8'h00);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        chk("mid_rst_busy", busy, 0);
        tick(2);
        rst = 1'b0;
        wait_for(1, 9, 60, "mid_rst_reread");
        ft_rxf_n = 1'b1;
        tick(10);
        chk("mid_rst_rx_byte", rx_got[$], 8'hC3);
        chk("mid_rst_rd_len", rd_lens[$], 6);
        chk("mid_rst_link_up", link_up, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
